// File: rtl/bus_transfer_arbiter.sv
//------------------------------------------------------------------------------
// Module  : bus_transfer_arbiter
// Purpose : Round-robin sequencer for the shared internal tristate bus; inserts
//           a dead cycle between drivers and pulses done on completion.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_transfer_arbiter #(
  parameter int NREQ  = 4,
  parameter int NSINK = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*NSINK-1:0]  dst,
  output logic [NREQ-1:0]        drive_en,
  output logic [NSINK-1:0]       load_en,
  output logic [NREQ-1:0]        done,
  output logic                   busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GAP   = 2'd1,
    S_DRIVE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q,  last_d;
  logic [NSINK-1:0]  dmask_q, dmask_d;

  logic [NREQ-1:0]   drive_en_q, drive_en_d;
  logic [NSINK-1:0]  load_en_q,  load_en_d;
  logic [NREQ-1:0]   done_q,     done_d;
  logic              busy_q,     busy_d;

  logic [NREQ-1:0]   arb_req;
  logic [GW-1:0]     cand;
  logic [GW-1:0]     win_idx;
  logic              win_vld;
  logic [NREQ-1:0]   grant_oh_d;

  // In HOLD the current grantee still shows req high; it must not win again.
  always_comb begin
    arb_req = req;
    if (state_q == S_HOLD) begin
      arb_req = req & ~(NREQ'(1) << grant_q);
    end
  end

  // Search starts just after the last grantee and wraps; first set bit wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(last_q) + k) % NREQ);
      if (!win_vld && arb_req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    dmask_d = dmask_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (win_vld) begin
          state_d = S_GAP;
          grant_d = win_idx;
          last_d  = win_idx;
          dmask_d = dst[int'(win_idx)*NSINK +: NSINK];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP:   state_d = S_DRIVE;
      S_DRIVE: state_d = S_HOLD;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next state so they are registered alongside it.
  always_comb begin
    grant_oh_d = NREQ'(1) << grant_d;
    drive_en_d = '0;
    load_en_d  = '0;
    done_d     = '0;
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_DRIVE: begin
        drive_en_d = grant_oh_d;
        load_en_d  = dmask_d;
      end
      S_HOLD: begin
        drive_en_d = grant_oh_d;
        done_d     = grant_oh_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      last_q     <= GW'(NREQ - 1);
      dmask_q    <= '0;
      drive_en_q <= '0;
      load_en_q  <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      dmask_q    <= dmask_d;
      drive_en_q <= drive_en_d;
      load_en_q  <= load_en_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign drive_en = drive_en_q;
  assign load_en  = load_en_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_transfer_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_bus_transfer_arbiter
// Purpose : Directed self-checking bench for bus_transfer_arbiter.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_transfer_arbiter;

  localparam int NREQ  = 4;
  localparam int NSINK = 4;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*NSINK-1:0] dst;
  logic [NREQ-1:0]       drive_en;
  logic [NSINK-1:0]      load_en;
  logic [NREQ-1:0]       done;
  logic                  busy;

  int checks;
  int failures;
  logic [NREQ-1:0] prev_drive;

  bus_transfer_arbiter #(.NREQ(NREQ), .NSINK(NSINK)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .dst      (dst),
    .drive_en (drive_en),
    .load_en  (load_en),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Bus invariants, sampled on the falling edge.
  always @(negedge clk) begin
    check("onehot0_drive", 32'($countones(drive_en) <= 1), 32'd1);
    check("load_needs_drive", 32'((load_en != '0) && (drive_en == '0)), 32'd0);
    check("dead_cycle", 32'((drive_en != '0) && (prev_drive != '0) && (drive_en != prev_drive)), 32'd0);
    prev_drive = drive_en;
  end

  initial begin
    checks     = 0;
    failures   = 0;
    prev_drive = '0;
    reset      = 1'b0;
    req        = '0;
    dst        = '0;
    step();
    step();
    check("rst_drive", 32'(drive_en), 32'h0);
    check("rst_load",  32'(load_en),  32'h0);
    check("rst_done",  32'(done),     32'h0);
    check("rst_busy",  32'(busy),     32'h0);
    reset = 1'b1;

    // Single request
    req = 4'b0001;
    dst[0*NSINK +: NSINK] = 4'b0101;
    step();
    check("single_gap_busy",  32'(busy),     32'h1);
    check("single_gap_drive", 32'(drive_en), 32'h0);
    step();
    check("single_drive",      32'(drive_en), 32'h1);
    check("single_load",       32'(load_en),  32'h5);
    check("single_drive_done", 32'(done),     32'h0);
    step();
    check("single_hold_drive", 32'(drive_en), 32'h1);
    check("single_hold_load",  32'(load_en),  32'h0);
    check("single_hold_done",  32'(done),     32'h1);
    req = '0;
    step();
    check("single_idle_busy",  32'(busy),     32'h0);
    check("single_idle_drive", 32'(drive_en), 32'h0);
    check("single_idle_done",  32'(done),     32'h0);

    // Round-robin fairness from a fresh pointer
    do_reset();
    dst = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    req = 4'b1111;
    for (int g = 0; g < NREQ; g++) begin
      step();
      check("rr_gap_busy",  32'(busy),     32'h1);
      check("rr_gap_drive", 32'(drive_en), 32'h0);
      step();
      check("rr_drive", 32'(drive_en), 32'(1 << g));
      check("rr_load",  32'(load_en),  32'(1 << g));
      step();
      check("rr_done",  32'(done),     32'(1 << g));
      req[g] = 1'b0;
    end
    step();
    check("rr_idle", 32'(busy), 32'h0);
    req = 4'b1001;
    step();
    step();
    check("rr2_first", 32'(drive_en), 32'h1);
    step();
    check("rr2_first_done", 32'(done), 32'h1);
    req = 4'b1000;
    step();
    step();
    check("rr2_second", 32'(drive_en), 32'h8);
    step();
    check("rr2_second_done", 32'(done), 32'h8);
    req = '0;
    step();
    check("rr2_idle", 32'(busy), 32'h0);

    // Continuous requests: bus never idles, monitor watches the gaps
    req = 4'b1111;
    step();
    for (int c = 0; c < 24; c++) begin
      step();
      check("cont_busy", 32'(busy), 32'h1);
    end
    req = '0;
    for (int c = 0; c < 4; c++) step();
    check("cont_idle", 32'(busy), 32'h0);

    // dst sampled only at grant, and empty mask
    do_reset();
    dst = '0;
    dst[1*NSINK +: NSINK] = 4'b0011;
    req = 4'b0010;
    step();
    dst[1*NSINK +: NSINK] = 4'b1100;
    step();
    check("dst_drive", 32'(drive_en), 32'h2);
    check("dst_load",  32'(load_en),  32'h3);
    step();
    check("dst_done", 32'(done), 32'h2);
    req = '0;
    step();
    dst[1*NSINK +: NSINK] = 4'b0000;
    req = 4'b0010;
    step();
    step();
    check("zmask_drive", 32'(drive_en), 32'h2);
    check("zmask_load",  32'(load_en),  32'h0);
    step();
    check("zmask_done", 32'(done),    32'h2);
    check("zmask_load_hold", 32'(load_en), 32'h0);
    req = '0;
    step();

    // Reset during DRIVE
    dst[2*NSINK +: NSINK] = 4'b1111;
    req = 4'b0100;
    step();
    step();
    check("mid_drive", 32'(drive_en), 32'h4);
    #2;
    reset = 1'b0;
    #1;
    check("mid_async_drive", 32'(drive_en), 32'h0);
    check("mid_async_load",  32'(load_en),  32'h0);
    check("mid_async_busy",  32'(busy),     32'h0);
    req = 4'b0110;
    step();
    check("mid_no_done", 32'(done), 32'h0);
    reset = 1'b1;
    step();
    check("mid_after_gap", 32'(busy), 32'h1);
    step();
    check("mid_after_grant1", 32'(drive_en), 32'h2);
    step();
    check("mid_after_done1", 32'(done), 32'h2);
    req = 4'b0100;
    step();
    step();
    check("mid_after_grant2", 32'(drive_en), 32'h4);
    step();
    req = '0;
    step();

    // Request held past done re-arbitrates after one IDLE cycle
    dst[2*NSINK +: NSINK] = 4'b0001;
    req = 4'b0100;
    step();
    step();
    step();
    check("held_done", 32'(done), 32'h4);
    step();
    check("held_idle_busy",  32'(busy),     32'h0);
    check("held_idle_drive", 32'(drive_en), 32'h0);
    step();
    check("held_gap_busy",  32'(busy),     32'h1);
    check("held_gap_drive", 32'(drive_en), 32'h0);
    step();
    check("held_drive", 32'(drive_en), 32'h4);
    check("held_load",  32'(load_en),  32'h1);
    step();
    check("held_done2", 32'(done), 32'h4);
    req = '0;
    step();
    check("held_final_idle", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
